// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_unit
// Purpose  : MEM-stage data memory. Byte/halfword/word loads and stores on a
//            2^ADDRESS_WIDTH-word array with a fixed stall latency. The load
//            result is presented to WB with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_unit #(
  parameter int ADDRESS_WIDTH  = 10,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [1:0]  access_size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        stall,
  output logic        misaligned
);

  localparam int                DEPTH      = 1 << ADDRESS_WIDTH;
  localparam int                CNT_W      = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  C_CNT_INIT = CNT_W'(ACCESS_LATENCY - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH+1:0] addr_q, addr_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     wr_q, wr_d;
  logic [31:0]              read_data_q, read_data_d;

  logic [31:0]              mem_array [0:DEPTH-1];

  logic                     w_req;
  logic                     w_mis;
  logic                     w_commit;
  logic [ADDRESS_WIDTH-1:0] w_index;
  logic [1:0]               w_lane;
  logic [31:0]              w_old;
  logic [31:0]              w_shift;
  logic [31:0]              w_wdata_rep;
  logic [3:0]               w_be;
  logic [31:0]              w_wr_word;
  logic [31:0]              w_load;
  logic                     w_unused;

  // Upper address bits only alias the array and are deliberately dropped.
  assign w_unused = ^{1'b0, address[31:ADDRESS_WIDTH+2]};

  assign w_req = memory_read | memory_write;
  // Halfwords need bit 0 clear; words (size 1x) need both low bits clear.
  assign w_mis = ((access_size == 2'b01) & address[0]) |
                 (access_size[1] & (|address[1:0]));

  // Next-state, request capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    read_valid = 1'b0;
    w_commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          if (w_mis) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = address[ADDRESS_WIDTH+1:0];
            size_d  = access_size;
            uns_d   = load_unsigned;
            wdata_d = write_data;
            wr_d    = memory_write;
            if (ACCESS_LATENCY == 1) begin
              state_d  = DONE;
              w_commit = 1'b1;
            end else begin
              state_d = BUSY;
              cnt_d   = C_CNT_INIT;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == C_CNT_ONE) begin
          state_d  = DONE;
          w_commit = 1'b1;
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      DONE: begin
        read_valid = ~wr_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // While reset is held every output stays low even if requests are present.
    if (!reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  // Lane merge for stores and lane extract/extend for loads. The *_d values
  // are the access being committed: live inputs when committing straight from
  // IDLE, otherwise the captured copy.
  always_comb begin
    w_index     = addr_d[ADDRESS_WIDTH+1:2];
    w_lane      = addr_d[1:0];
    w_old       = mem_array[w_index];
    w_shift     = w_old >> {w_lane, 3'b000};
    w_wdata_rep = wdata_d;
    w_be        = 4'b1111;
    w_load      = w_old;
    case (size_d)
      2'b00: begin
        w_wdata_rep = {4{wdata_d[7:0]}};
        w_be        = 4'b0001 << w_lane;
        w_load      = uns_d ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      2'b01: begin
        w_wdata_rep = {2{wdata_d[15:0]}};
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_load      = uns_d ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        w_wdata_rep = wdata_d;
        w_be        = 4'b1111;
        w_load      = w_old;
      end
    endcase
    w_wr_word = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_wr_word[8*i +: 8] = w_wdata_rep[8*i +: 8];
    end
    read_data_d = read_data_q;
    if (w_commit && !wr_d) read_data_d = w_load;
  end

  // Control and load-result registers.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      read_data_q <= read_data_d;
    end
  end

  // Storage array: not reset; writes are blocked while reset is asserted.
  always_ff @(posedge system_clock) begin
    if (w_commit && wr_d && reset) mem_array[w_index] <= w_wr_word;
  end

  assign read_data = read_data_q;

endmodule
`default_nettype wire

// File: doc/data_memory_unit.md
# data_memory_unit

MEM-stage data memory for the `mips` pipeline: accepts the EX-stage ALU result as a byte address and performs word, halfword or byte loads and stores on a 2^ADDRESS_WIDTH-word on-chip array. Access takes a fixed, parameterised number of stall cycles. The block asserts `stall` to freeze upstream stages until the access completes, then presents load data to the WB stage for exactly one cycle.

## Interface
- `ADDRESS_WIDTH`, 10, word-address width; the array holds 2^ADDRESS_WIDTH 32-bit words.
- `ACCESS_LATENCY`, 2, number of stall cycles per accepted access; legal range ≥ 1.

- `system_clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memory_read`  in  1  load request from the control unit.
- `memory_write`  in  1  store request from the control unit.
- `access_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `load_unsigned`  in  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- `address`  in  32  byte address, normally `alu_result`.
- `write_data`  in  32  store data; sub-word stores use the low bits.
- `read_data`  out  32  load result; reset value 0.
- `read_valid`  out  1  one-cycle pulse when `read_data` is updated by a load; reset value 0.
- `stall`  out  1  hold upstream pipeline; reset value 0.
- `misaligned`  out  1  combinational flag marking a rejected request; reset value 0.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset forces IDLE, counter 0, `read_data` 0, all outputs low. Array contents are not reset.
- Request = `memory_read | memory_write`, sampled only in IDLE. If both are high, the write wins and no read is performed.
- Alignment check in IDLE:
  - Halfword requires `address[0]==0`.
  - Word requires `address[1:0]==0`.
  - On violation: `misaligned`=1 that cycle, `stall`=0, no state change, no array or `read_data` change.
- Aligned request in IDLE:
  - `address`, size, `load_unsigned`, `write_data` and direction are captured into internal registers.
  - `stall`=1 combinationally in the same cycle.
  - Next state is DONE if ACCESS_LATENCY==1. Otherwise BUSY, with counter = ACCESS_LATENCY−1.
- BUSY: `stall`=1; input changes are ignored. When counter==1, next state is DONE; else the counter decrements.
- Access commits on the clock edge entering DONE:
  - Word index = `address[ADDRESS_WIDTH+1:2]`; higher address bits are ignored, so addresses wrap modulo the array size.
  - Store: little-endian byte-lane merge. A byte store writes lane `address[1:0]`; a halfword store writes lanes {1,0} or {3,2}; other lanes are preserved.
  - Load: select the lane(s) the same way, then zero- or sign-extend to 32 bits and register the result into `read_data`.
- DONE, one cycle: `stall`=0; `read_valid`=1 if the access was a load. Next state is IDLE unconditionally; the still-held request inputs are ignored.
- `read_data` holds its value until the next load commits. Stores never change it.

## Timing
- For an aligned request first presented in cycle 0:
  - `stall` is high in cycles 0 … ACCESS_LATENCY−1.
  - Cycle ACCESS_LATENCY is DONE: `stall` low, `read_valid` pulses for a load.
  - The earliest next request is accepted in cycle ACCESS_LATENCY+1.
- Back-to-back accesses therefore occupy ACCESS_LATENCY+1 cycles each.
- Read-after-write to the same word: the load returns the newly stored data, because the store commits before the load is accepted.
- Reset asserted mid-BUSY: immediate return to IDLE, `stall` 0, and the pending store is discarded. Reset in the DONE cycle leaves an already-committed store in place but clears `read_data`.
- No request and misaligned requests cost zero cycles.

## Test plan
- Word store then load, ACCESS_LATENCY=2:
  - Store 0xDEADBEEF at 0x10, then load from 0x10.
  - Required: `stall` high for 2 cycles per access; `read_data`=0xDEADBEEF with `read_valid` pulsing in the 3rd cycle of the load.
- Byte loads:
  - Store word 0x00008000 at 0x20, then load the byte at 0x21, signed.
  - Required: 0xFFFFFF80. The same load unsigned → 0x00000080. Halfword at 0x20 signed → 0xFFFF8000.
- Sub-word merge:
  - Store word 0x11223344 at 0x30; store byte 0xAA at 0x32; store halfword 0xBBCC at 0x30.
  - Required: a word load of 0x30 returns 0x11AABBCC.
- Misaligned:
  - Word load at 0x06; halfword store at 0x0B.
  - Required: `misaligned`=1 for one cycle, `stall`=0, array and `read_data` unchanged.
- Reset mid-access:
  - Store 0x12345678 at 0x40 and drop `reset` during the first BUSY cycle; release reset, then load 0x40.
  - Required: the previous value is returned; `stall` is 0 while reset is asserted.
- Wrap and minimum latency, ACCESS_LATENCY=1:
  - Store 0xCAFEF00D at 0x1000, then load 0x0.
  - Required: 0xCAFEF00D, one stall cycle per access, next request accepted in cycle 2.
